path_mailbox_host: RTL and testbench
====================================

// Module: path_mailbox_host
// PURPOSE
//  Host-side controller for the path-finding mailbox at 0x0200_0000..0x0200_000C.
//  Holds the CPU in reset, loads START/END/NODE/DONE words over the external memory port, releases the CPU.
//  Captures every NODE_POINT write into a path buffer and flags completion when CPU_DONE is written with 1.
//  Sits between the system/test host and risc_v_cpu's Ext_* and MemWrite/DataAdr/WriteData ports.
// PARAMETERS
//  DEPTH      16      path buffer entries (power of two, >=2)
//  NODE_W     5       node index width
//  WDOG_CYC   100000  watchdog limit in RUN cycles (used only with MBX_WATCHDOG_EN)
// PORTS
//  clk           in   1       single clock; all state on rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  start         in   1       1-cycle pulse: begin a run (accepted in IDLE/DONE/TIMEOUT only)
//  start_point   in   NODE_W  START_POINT value, sampled on accepted start
//  end_point     in   NODE_W  END_POINT value, sampled on accepted start
//  cpu_reset     out  1       active-high reset to CPU
//  ext_memwrite  out  1       to CPU Ext_MemWrite
//  ext_wdata     out  32      to CPU Ext_WriteData
//  ext_adr       out  32      to CPU Ext_DataAdr
//  cpu_memwrite  in   1       CPU MemWrite
//  cpu_adr       in   32      CPU DataAdr
//  cpu_wdata     in   32      CPU WriteData
//  busy          out  1       high from LOAD through RUN
//  done          out  1       high in DONE
//  overflow      out  1       node write arrived with buffer full (sticky until next start)
//  path_len      out  $clog2(DEPTH)+1  nodes captured
//  rd_idx        in   $clog2(DEPTH)    buffer read index
//  rd_node       out  NODE_W  buffer[rd_idx], combinational read
// BEHAVIOUR
//  Reset: state=IDLE, cpu_reset=1, ext_*=0, busy=done=overflow=0, path_len=0.
//  FSM: IDLE -start-> LOAD -> RUN -> DONE; RUN -> TIMEOUT (watchdog only). DONE/TIMEOUT -start-> LOAD.
//  LOAD: 8 cycles, cpu_reset=1. Even step k: ext_memwrite=1, ext_adr=0x0200_0000+4*(k/2),
//   ext_wdata = {SP, EP, 0, 0}[k/2] zero-extended; odd step: ext_memwrite=0, ext_adr=0, ext_wdata=0.
//  On accepted start: SP/EP latched, path_len=0, overflow=0, done=0.
//  RUN: first cycle after LOAD; cpu_reset=0, ext_*=0.
//   Capture: cpu_memwrite && cpu_adr==0x0200_0008 -> buffer[path_len]=cpu_wdata[NODE_W-1:0], path_len++.
//   Full (path_len==DEPTH): entry dropped, path_len holds, overflow=1.
//   cpu_memwrite && cpu_adr==0x0200_000C && cpu_wdata==1 -> DONE next cycle; other values ignored.
//   Writes to other addresses ignored. Address and data compared in full 32 bits.
//  DONE: cpu_reset=1 (CPU frozen), done=1, buffer and path_len held for readout.
//  start during LOAD/RUN ignored. reset_n low at any point aborts to reset values next edge.
//  Capture latency: path_len updates 1 cycle after the CPU write cycle.
// CONFIGURATION
//  MBX_WATCHDOG_EN defined: 32-bit RUN cycle counter; at WDOG_CYC -> TIMEOUT
//   (cpu_reset=1, done=0, busy=0; buffer held). Counter clears on LOAD entry.
//  Undefined: no counter, no TIMEOUT state; RUN lasts until CPU_DONE. WDOG_CYC unused.
// STRUCTURE
//  Package mbx_pkg: MBX_SP_ADR, MBX_EP_ADR, MBX_NODE_ADR, MBX_DONE_ADR localparams; state enum.
//  Sub-module mbx_path_buf: DEPTH x NODE_W register file, write port + count, full flag, comb read.
//  Top holds FSM, LOAD sequencer, address decode, watchdog.
// TESTING
//  start with SP=3, EP=11 -> ext writes 3@0x0200_0000, 11@..04, 0@..08, 0@..0C on alternate cycles; cpu_reset falls after.
//  Model CPU writes 3,7,11 to 0x0200_0008 then 1 to 0x0200_000C -> path_len=3, rd_node[0..2]=3,7,11, done=1, cpu_reset=1.
//  18 node writes with DEPTH=16 -> path_len=16, overflow=1, entries 0..15 hold first 16 values.
//  Write 2 to 0x0200_000C, then 0x0200_0010 stores -> no done, path_len unchanged; then 1 -> done.
//  reset_n low mid-LOAD and mid-RUN -> all outputs at reset values; start during RUN ignored.
//  MBX_WATCHDOG_EN, WDOG_CYC=50, silent CPU -> TIMEOUT at RUN cycle 50, cpu_reset=1, done=0.

Source files
------------

// File: rtl/mbx_pkg.sv
// Shared mailbox addresses and host FSM states for path_mailbox_host.
// MBX_WATCHDOG_EN adds the TIMEOUT state.
package mbx_pkg;

  localparam logic [31:0] MBX_SP_ADR   = 32'h0200_0000;
  localparam logic [31:0] MBX_EP_ADR   = 32'h0200_0004;
  localparam logic [31:0] MBX_NODE_ADR = 32'h0200_0008;
  localparam logic [31:0] MBX_DONE_ADR = 32'h0200_000C;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
`ifdef MBX_WATCHDOG_EN
    StTimeout,
`endif
    StDone
  } mbx_state_e;

endpackage

// File: rtl/mbx_path_buf.sv
// Path buffer: DEPTH x NODE_W register file with fill count, full flag and
// combinational read port.
module mbx_path_buf #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NODE_W = 5,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [NODE_W-1:0] wr_data,
  output logic [IdxW:0]     count,
  output logic              full,
  input  logic [IdxW-1:0]   rd_idx,
  output logic [NODE_W-1:0] rd_node
);

  logic [NODE_W-1:0] r_mem [DEPTH];
  logic [IdxW:0]     r_count;
  logic              w_push;

  assign full    = (r_count == (IdxW+1)'(DEPTH));
  assign w_push  = wr_en && !full;
  assign count   = r_count;
  assign rd_node = r_mem[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_push) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Storage needs no reset; count gates what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_count[IdxW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/path_mailbox_host.sv
// Host-side controller for the path-finding mailbox: loads START/END/NODE/DONE
// words, runs the CPU, captures node writes. MBX_WATCHDOG_EN adds a RUN watchdog.
module path_mailbox_host
  import mbx_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NODE_W   = 5,
  parameter int unsigned WDOG_CYC = 100000,
  localparam int unsigned IdxW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NODE_W-1:0] start_point,
  input  logic [NODE_W-1:0] end_point,
  output logic              cpu_reset,
  output logic              ext_memwrite,
  output logic [31:0]       ext_wdata,
  output logic [31:0]       ext_adr,
  input  logic              cpu_memwrite,
  input  logic [31:0]       cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [IdxW:0]     path_len,
  input  logic [IdxW-1:0]   rd_idx,
  output logic [NODE_W-1:0] rd_node
);

  mbx_state_e        r_state, w_state_nxt;
  logic [2:0]        r_step;
  logic [NODE_W-1:0] r_sp, r_ep;
  logic              r_overflow;
  logic              w_accept;
  logic              w_node_wr;
  logic              w_done_wr;
  logic              w_full;

  assign w_node_wr = (r_state == StRun) && cpu_memwrite && (cpu_adr == MBX_NODE_ADR);
  assign w_done_wr = (r_state == StRun) && cpu_memwrite && (cpu_adr == MBX_DONE_ADR)
                     && (cpu_wdata == 32'd1);

`ifdef MBX_WATCHDOG_EN
  logic [31:0] r_wdog;
  logic        w_wdog_hit;

  assign w_wdog_hit = (r_wdog == 32'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (w_accept) begin
      r_wdog <= '0;
    end else if (r_state == StRun) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StLoad;
          w_accept    = 1'b1;
        end
      end
`ifdef MBX_WATCHDOG_EN
      StTimeout: begin
        if (start) begin
          w_state_nxt = StLoad;
          w_accept    = 1'b1;
        end
      end
`endif
      StLoad: begin
        if (r_step == 3'd7) w_state_nxt = StRun;
      end
      StRun: begin
        if (w_done_wr) begin
          w_state_nxt = StDone;
`ifdef MBX_WATCHDOG_EN
        end else if (w_wdog_hit) begin
          w_state_nxt = StTimeout;
`endif
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_step     <= '0;
      r_sp       <= '0;
      r_ep       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_step     <= '0;
        r_sp       <= start_point;
        r_ep       <= end_point;
        r_overflow <= 1'b0;
      end else begin
        if (r_state == StLoad) r_step <= r_step + 3'd1;
        if (w_node_wr && w_full) r_overflow <= 1'b1;
      end
    end
  end

  // Even LOAD steps write mailbox word step/2; odd steps idle the port.
  always_comb begin
    ext_memwrite = 1'b0;
    ext_adr      = '0;
    ext_wdata    = '0;
    if (r_state == StLoad && !r_step[0]) begin
      ext_memwrite = 1'b1;
      ext_adr      = MBX_SP_ADR + {27'd0, r_step[2:1], 2'b00};
      case (r_step[2:1])
        2'd0:    ext_wdata = 32'(r_sp);
        2'd1:    ext_wdata = 32'(r_ep);
        default: ext_wdata = '0;
      endcase
    end
  end

  assign cpu_reset = (r_state != StRun);
  assign busy      = (r_state == StLoad) || (r_state == StRun);
  assign done      = (r_state == StDone);
  assign overflow  = r_overflow;

  mbx_path_buf #(
    .DEPTH  (DEPTH),
    .NODE_W (NODE_W)
  ) u_path_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_accept),
    .wr_en   (w_node_wr),
    .wr_data (cpu_wdata[NODE_W-1:0]),
    .count   (path_len),
    .full    (w_full),
    .rd_idx  (rd_idx),
    .rd_node (rd_node)
  );

endmodule

// File: tb/tb_path_mailbox_host.sv
// Directed bench for path_mailbox_host; watchdog test runs when MBX_WATCHDOG_EN is defined.
module tb_path_mailbox_host;

`ifdef MBX_WATCHDOG_EN
  localparam int unsigned WDOG = 50;
`else
  localparam int unsigned WDOG = 100000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  start_point, end_point;
  logic        cpu_reset, ext_memwrite;
  logic [31:0] ext_wdata, ext_adr;
  logic        cpu_memwrite;
  logic [31:0] cpu_adr, cpu_wdata;
  logic        busy, done, overflow;
  logic [4:0]  path_len;
  logic [3:0]  rd_idx;
  logic [4:0]  rd_node;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  path_mailbox_host #(
    .DEPTH    (16),
    .NODE_W   (5),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_point  (start_point),
    .end_point    (end_point),
    .cpu_reset    (cpu_reset),
    .ext_memwrite (ext_memwrite),
    .ext_wdata    (ext_wdata),
    .ext_adr      (ext_adr),
    .cpu_memwrite (cpu_memwrite),
    .cpu_adr      (cpu_adr),
    .cpu_wdata    (cpu_wdata),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .path_len     (path_len),
    .rd_idx       (rd_idx),
    .rd_node      (rd_node)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, " ext_memwrite"}, 32'(ext_memwrite), 32'd0);
    check_eq({tag, " ext_adr"}, ext_adr, 32'd0);
    check_eq({tag, " ext_wdata"}, ext_wdata, 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " done"}, 32'(done), 32'd0);
    check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, " path_len"}, 32'(path_len), 32'd0);
  endtask

  // Pulse start, check every LOAD step, then the first RUN cycle.
  task automatic run_load(input logic [4:0] sp, input logic [4:0] ep);
    logic [31:0] exp_adr, exp_dat;
    start       = 1'b1;
    start_point = sp;
    end_point   = ep;
    tick();
    start       = 1'b0;
    start_point = 5'd0;
    end_point   = 5'd0;
    for (int k = 0; k < 8; k++) begin
      exp_adr = 32'd0;
      exp_dat = 32'd0;
      if (k % 2 == 0) begin
        exp_adr = 32'h0200_0000 + 32'(4 * (k / 2));
        if (k == 0) exp_dat = 32'(sp);
        if (k == 2) exp_dat = 32'(ep);
      end
      check_eq($sformatf("load%0d memwrite", k), 32'(ext_memwrite), 32'(k % 2 == 0));
      check_eq($sformatf("load%0d adr", k), ext_adr, exp_adr);
      check_eq($sformatf("load%0d wdata", k), ext_wdata, exp_dat);
      check_eq($sformatf("load%0d cpu_reset", k), 32'(cpu_reset), 32'd1);
      check_eq($sformatf("load%0d busy", k), 32'(busy), 32'd1);
      if (k < 7) tick();
    end
    tick();
    check_eq("run cpu_reset", 32'(cpu_reset), 32'd0);
    check_eq("run ext_memwrite", 32'(ext_memwrite), 32'd0);
    check_eq("run ext_adr", ext_adr, 32'd0);
    check_eq("run busy", 32'(busy), 32'd1);
    check_eq("run path_len", 32'(path_len), 32'd0);
  endtask

  task automatic cpu_wr(input logic [31:0] adr, input logic [31:0] dat);
    cpu_memwrite = 1'b1;
    cpu_adr      = adr;
    cpu_wdata    = dat;
    tick();
    cpu_memwrite = 1'b0;
    cpu_adr      = 32'd0;
    cpu_wdata    = 32'd0;
  endtask

  task automatic check_node(input int idx, input logic [4:0] exp);
    rd_idx = 4'(idx);
    #1;
    check_eq($sformatf("rd_node[%0d]", idx), 32'(rd_node), 32'(exp));
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    start_point  = 5'd0;
    end_point    = 5'd0;
    cpu_memwrite = 1'b0;
    cpu_adr      = 32'd0;
    cpu_wdata    = 32'd0;
    rd_idx       = 4'd0;
    tick();
    tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();
    check_reset_vals("idle");

    // Basic run: SP=3, EP=11, path 3,7,11.
    run_load(5'd3, 5'd11);
    cpu_wr(32'h0200_0008, 32'd3);
    check_eq("p1 len1", 32'(path_len), 32'd1);
    cpu_wr(32'h0200_0008, 32'd7);
    cpu_wr(32'h0200_0008, 32'd11);
    check_eq("p1 len3", 32'(path_len), 32'd3);
    check_eq("p1 not done", 32'(done), 32'd0);
    cpu_wr(32'h0200_000C, 32'd1);
    check_eq("p1 done", 32'(done), 32'd1);
    check_eq("p1 cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("p1 busy", 32'(busy), 32'd0);
    check_eq("p1 len held", 32'(path_len), 32'd3);
    check_eq("p1 overflow", 32'(overflow), 32'd0);
    check_node(0, 5'd3);
    check_node(1, 5'd7);
    check_node(2, 5'd11);

    // Overflow, start-in-RUN, non-1 DONE and stray addresses.
    run_load(5'd1, 5'd2);
    check_eq("p2 done cleared", 32'(done), 32'd0);
    for (int i = 0; i < 18; i++) cpu_wr(32'h0200_0008, 32'(i + 20));
    check_eq("p2 len full", 32'(path_len), 32'd16);
    check_eq("p2 overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) check_node(i, 5'(i + 20));
    start       = 1'b1;
    start_point = 5'd9;
    tick();
    start = 1'b0;
    check_eq("start in run cpu_reset", 32'(cpu_reset), 32'd0);
    check_eq("start in run memwrite", 32'(ext_memwrite), 32'd0);
    check_eq("start in run len", 32'(path_len), 32'd16);
    cpu_wr(32'h0200_000C, 32'd2);
    check_eq("done=2 ignored", 32'(done), 32'd0);
    cpu_wr(32'h0200_0010, 32'd1);
    cpu_wr(32'h0200_0010, 32'd5);
    cpu_wr(32'h0300_0008, 32'd5);
    check_eq("stray no done", 32'(done), 32'd0);
    check_eq("stray busy", 32'(busy), 32'd1);
    check_eq("stray len", 32'(path_len), 32'd16);
    cpu_wr(32'h0200_000C, 32'd1);
    check_eq("p2 done", 32'(done), 32'd1);
    check_eq("p2 overflow sticky", 32'(overflow), 32'd1);

    // Restart from DONE clears overflow and count.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart overflow", 32'(overflow), 32'd0);
    check_eq("restart len", 32'(path_len), 32'd0);
    check_eq("restart busy", 32'(busy), 32'd1);

    // Abort mid-LOAD.
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort load");
    tick();
    reset_n = 1'b1;
    tick();
    check_reset_vals("post abort load");

    // Abort mid-RUN.
    run_load(5'd4, 5'd5);
    cpu_wr(32'h0200_0008, 32'd6);
    check_eq("p3 len", 32'(path_len), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort run");
    tick();
    reset_n = 1'b1;
    tick();
    check_reset_vals("post abort run");

`ifdef MBX_WATCHDOG_EN
    // Silent CPU: 50 RUN cycles, then TIMEOUT.
    run_load(5'd2, 5'd3);
    for (int i = 0; i < 49; i++) tick();
    check_eq("wdog cycle50 busy", 32'(busy), 32'd1);
    check_eq("wdog cycle50 cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    check_eq("wdog busy", 32'(busy), 32'd0);
    check_eq("wdog done", 32'(done), 32'd0);
    check_eq("wdog cpu_reset", 32'(cpu_reset), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wdog restart busy", 32'(busy), 32'd1);
    check_eq("wdog restart memwrite", 32'(ext_memwrite), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
